// File: rtl/ppu_hazard_controller_pkg.sv
// ppu_ctrl_pkg: shared definitions for the PPU hazard controller.
//   - bit positions inside the 22-bit ID control vector
//   - forwarding-select encodings
//   - sequencer FSM state encodings
//   - shadow-pipeline slot record
package ppu_ctrl_pkg;

  localparam int unsigned CTRL_W      = 22;
  localparam int unsigned CTRL_R31    = 20;
  localparam int unsigned CTRL_SRC_HI = 17;
  localparam int unsigned CTRL_SRC_LO = 15;
  localparam int unsigned CTRL_LOAD   = 9;
  localparam int unsigned CTRL_RFEN   = 8;
  localparam int unsigned CTRL_MEMRW  = 4;
  localparam int unsigned CTRL_MEMEN  = 2;

  // Operand source selects
  typedef enum logic [1:0] {
    FwdRf  = 2'b00,
    FwdEx  = 2'b01,
    FwdMem = 2'b10,
    FwdWb  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    StFlush   = 2'b00,
    StRun     = 2'b01,
    StMemWait = 2'b10
  } state_e;

  // Destination record carried by the EX shadow slot
  typedef struct packed {
    logic [4:0] dest;
    logic       we;
    logic       load;
  } shadow_t;

endpackage

// File: rtl/ppu_hazard_controller_if.sv
// ppu_hazard_controller_if: ID-stage control/register fields and the pipeline
// control outputs of the hazard controller.
//   master : pipeline side, drives id_ctrl/id_rs/id_rt/id_dest/mem_busy,
//            receives load enables, bubble, forwarding selects, status.
//   slave  : hazard controller side (directions reversed).
interface ppu_hazard_controller_if #(
  parameter int unsigned CNT_W = 16
);
  logic [21:0]      id_ctrl;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_dest;
  logic             mem_busy;
  logic             pc_le;
  logic             ifid_le;
  logic             id_nop;
  logic             idex_le;
  logic             exmem_le;
  logic             memwb_le;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_ctrl, id_rs, id_rt, id_dest, mem_busy,
    input  pc_le, ifid_le, id_nop, idex_le, exmem_le, memwb_le,
    input  fwd_a_sel, fwd_b_sel, mem_timeout, stall_count
  );

  modport slave (
    input  id_ctrl, id_rs, id_rt, id_dest, mem_busy,
    output pc_le, ifid_le, id_nop, idex_le, exmem_le, memwb_le,
    output fwd_a_sel, fwd_b_sel, mem_timeout, stall_count
  );
endinterface

// File: rtl/ppu_hazard_controller_forward_unit.sv
// ppu_forward_unit: priority comparator choosing the source of one ID operand.
//   i_en          : 0 forces the register-file select
//   i_src         : operand register number
//   i_ex_*        : EX shadow slot (loads are not forwardable from EX)
//   i_mem_*       : MEM shadow slot
//   i_wb_*        : WB shadow slot
//   o_sel         : youngest matching producer wins; $0 never matches
module ppu_forward_unit
  import ppu_ctrl_pkg::*;
(
  input  logic       i_en,
  input  logic [4:0] i_src,
  input  logic [4:0] i_ex_dest,
  input  logic       i_ex_we,
  input  logic       i_ex_load,
  input  logic [4:0] i_mem_dest,
  input  logic       i_mem_we,
  input  logic [4:0] i_wb_dest,
  input  logic       i_wb_we,
  output fwd_sel_e   o_sel
);
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_ex_hit  = i_ex_we & ~i_ex_load & (i_ex_dest != 5'd0) & (i_ex_dest == i_src);
  assign w_mem_hit = i_mem_we & (i_mem_dest != 5'd0) & (i_mem_dest == i_src);
  assign w_wb_hit  = i_wb_we & (i_wb_dest != 5'd0) & (i_wb_dest == i_src);

  always_comb begin
    o_sel = FwdRf;
    if (!i_en) begin
      o_sel = FwdRf;
    end else if (w_ex_hit) begin
      o_sel = FwdEx;
    end else if (w_mem_hit) begin
      o_sel = FwdMem;
    end else if (w_wb_hit) begin
      o_sel = FwdWb;
    end
  end
endmodule

// File: rtl/ppu_hazard_controller.sv
// ppu_hazard_controller: pipeline sequencer beside the PPU ID stage.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, forces the drain (FLUSH) sequence
//   bus   : slave side of ppu_hazard_controller_if (ID fields in, pipeline
//           load enables / bubble / forwarding selects / status out)
// Keeps a shadow of the EX/MEM/WB destinations, stalls one cycle on load-use,
// freezes the pipe while data memory is busy and releases it via a watchdog.
module ppu_hazard_controller
  import ppu_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input logic                    clk,
  input logic                    reset,
  ppu_hazard_controller_if.slave bus
);
  localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WaitW  = $clog2(WAIT_TIMEOUT + 1);

  state_e           r_state;
  state_e           w_state_d;
  logic [FlushW-1:0] r_flush_cnt;
  logic [FlushW-1:0] w_flush_d;
  logic [WaitW-1:0] r_wait_cnt;
  logic [WaitW-1:0] w_wait_d;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;

  shadow_t          r_ex;
  logic [4:0]       r_mem_dest;
  logic             r_mem_we;
  logic [4:0]       r_wb_dest;
  logic             r_wb_we;

  logic             w_id_we;
  logic             w_id_load;
  logic             w_rs_used;
  logic             w_rt_used;
  logic             w_load_use;
  logic             w_wait_hit;
  logic             w_fwd_en;
  shadow_t          w_id_slot;

  logic             w_pc_le;
  logic             w_ifid_le;
  logic             w_id_nop;
  logic             w_idex_le;
  logic             w_exmem_le;
  logic             w_memwb_le;
  fwd_sel_e         w_fwd_a;
  fwd_sel_e         w_fwd_b;

  // ID control-vector decode
  assign w_id_we   = bus.id_ctrl[CTRL_RFEN];
  assign w_id_load = bus.id_ctrl[CTRL_LOAD] & bus.id_ctrl[CTRL_MEMEN] & ~bus.id_ctrl[CTRL_MEMRW];
  assign w_rs_used = ~bus.id_ctrl[CTRL_R31];
  assign w_rt_used = (bus.id_ctrl[CTRL_SRC_HI:CTRL_SRC_LO] == 3'b000) |
                     (bus.id_ctrl[CTRL_MEMEN] & ~bus.id_ctrl[CTRL_LOAD]);

  logic w_unused_ctrl;
  assign w_unused_ctrl = ^{bus.id_ctrl[21], bus.id_ctrl[19:18], bus.id_ctrl[14:10],
                           bus.id_ctrl[7:5], bus.id_ctrl[3], bus.id_ctrl[1:0]};

  assign w_load_use = r_ex.load & r_ex.we & (r_ex.dest != 5'd0) &
                      ((w_rs_used & (r_ex.dest == bus.id_rs)) |
                       (w_rt_used & (r_ex.dest == bus.id_rt)));

  assign w_id_slot = '{dest: bus.id_dest, we: w_id_we, load: w_id_load};

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StFlush;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_flush_cnt <= w_flush_d;
      r_wait_cnt  <= w_wait_d;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_d  = r_state;
    w_flush_d  = r_flush_cnt;
    w_wait_d   = r_wait_cnt;
    w_wait_hit = 1'b0;
    case (r_state)
      StFlush: begin
        if (r_flush_cnt == FlushW'(FLUSH_CYCLES - 1)) begin
          w_state_d = StRun;
          w_flush_d = '0;
        end else begin
          w_flush_d = r_flush_cnt + FlushW'(1);
        end
      end
      StRun: begin
        if (bus.mem_busy) begin
          w_state_d = StMemWait;
          w_wait_d  = '0;
        end
      end
      StMemWait: begin
        if (!bus.mem_busy) begin
          w_state_d = StRun;
        end else if (r_wait_cnt == WaitW'(WAIT_TIMEOUT)) begin
          // Watchdog: let one cycle through even though memory still reports busy
          w_state_d  = StRun;
          w_wait_hit = 1'b1;
        end else begin
          w_wait_d = r_wait_cnt + WaitW'(1);
        end
      end
      default: w_state_d = StFlush;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_pc_le    = 1'b1;
    w_ifid_le  = 1'b1;
    w_id_nop   = 1'b0;
    w_idex_le  = 1'b1;
    w_exmem_le = 1'b1;
    w_memwb_le = 1'b1;
    case (r_state)
      StFlush: begin
        w_pc_le   = 1'b0;
        w_ifid_le = 1'b0;
        w_id_nop  = 1'b1;
      end
      StRun, StMemWait: begin
        if (bus.mem_busy && !w_wait_hit) begin
          w_pc_le    = 1'b0;
          w_ifid_le  = 1'b0;
          w_idex_le  = 1'b0;
          w_exmem_le = 1'b0;
          w_memwb_le = 1'b0;
        end else if (!bus.mem_busy && w_load_use) begin
          w_pc_le   = 1'b0;
          w_ifid_le = 1'b0;
          w_id_nop  = 1'b1;
        end
      end
      default: begin
        w_pc_le   = 1'b0;
        w_ifid_le = 1'b0;
        w_id_nop  = 1'b1;
      end
    endcase
  end

  // Shadow of destinations in flight, stepping with the real pipeline registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex       <= '0;
      r_mem_dest <= '0;
      r_mem_we   <= 1'b0;
      r_wb_dest  <= '0;
      r_wb_we    <= 1'b0;
    end else begin
      if (w_idex_le) begin
        r_ex <= w_id_nop ? '0 : w_id_slot;
      end
      if (w_exmem_le) begin
        r_mem_dest <= r_ex.dest;
        r_mem_we   <= r_ex.we;
      end
      if (w_memwb_le) begin
        r_wb_dest <= r_mem_dest;
        r_wb_we   <= r_mem_we;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_wait_hit) begin
        r_timeout <= 1'b1;
      end
      if ((r_state != StFlush) && !w_pc_le && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign w_fwd_en = (r_state != StFlush);

  ppu_forward_unit u_fwd_a (
    .i_en       (w_fwd_en),
    .i_src      (bus.id_rs),
    .i_ex_dest  (r_ex.dest),
    .i_ex_we    (r_ex.we),
    .i_ex_load  (r_ex.load),
    .i_mem_dest (r_mem_dest),
    .i_mem_we   (r_mem_we),
    .i_wb_dest  (r_wb_dest),
    .i_wb_we    (r_wb_we),
    .o_sel      (w_fwd_a)
  );

  ppu_forward_unit u_fwd_b (
    .i_en       (w_fwd_en),
    .i_src      (bus.id_rt),
    .i_ex_dest  (r_ex.dest),
    .i_ex_we    (r_ex.we),
    .i_ex_load  (r_ex.load),
    .i_mem_dest (r_mem_dest),
    .i_mem_we   (r_mem_we),
    .i_wb_dest  (r_wb_dest),
    .i_wb_we    (r_wb_we),
    .o_sel      (w_fwd_b)
  );

  assign bus.pc_le       = w_pc_le;
  assign bus.ifid_le     = w_ifid_le;
  assign bus.id_nop      = w_id_nop;
  assign bus.idex_le     = w_idex_le;
  assign bus.exmem_le    = w_exmem_le;
  assign bus.memwb_le    = w_memwb_le;
  assign bus.fwd_a_sel   = w_fwd_a;
  assign bus.fwd_b_sel   = w_fwd_b;
  assign bus.mem_timeout = r_timeout;
  assign bus.stall_count = r_stall_cnt;
endmodule

// File: doc/ppu_hazard_controller.md
Name: ppu_hazard_controller

Overview:
Pipeline sequencer for the PPU five-stage MIPS core. It sits beside the ID stage and consumes the 22-bit control vector from PPU_Control_Unit together with the ID-stage register fields. It keeps a shadow of EX/MEM/WB destinations and uses it to generate:
- pipeline-register load enables
- bubble injection
- forwarding selects
- a reset drain sequence and data-memory wait handling with a watchdog

Parameters:
FLUSH_CYCLES, 3, cycles of forced bubbles after reset before normal issue
WAIT_TIMEOUT, 255, maximum consecutive mem_busy cycles before watchdog release
CNT_W, 16, width of stall_count

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
id_ctrl  in  22  control vector of the ID instruction. Bit meanings: 21 cond/uncond jump, 20 R31, 19 uncond jump, 18 dest reg, 17:15 source operand, 14:11 ALU op, 10 B instr, 9 load instr, 8 RF enable, 7 TA instr, 6:5 mem size, 4 mem RW, 3 mem SE, 2 mem enable, 1 HI enable, 0 LO enable
id_rs  in  5  ID instruction[25:21]
id_rt  in  5  ID instruction[20:16]
id_dest  in  5  final destination register from the ID destination mux
mem_busy  in  1  data memory not ready; MEM stage must hold
pc_le  out  1  PC load enable
ifid_le  out  1  IF/ID load enable
id_nop  out  1  1 = ID/EX control input forced to 22'b0
idex_le  out  1  ID/EX load enable
exmem_le  out  1  EX/MEM load enable
memwb_le  out  1  MEM/WB load enable
fwd_a_sel  out  2  rs operand source: 00 RF, 01 EX result, 10 MEM result, 11 WB result
fwd_b_sel  out  2  rt operand source, same encoding as fwd_a_sel
mem_timeout  out  1  sticky watchdog flag
stall_count  out  CNT_W  saturating count of cycles with pc_le=0 in RUN or MEM_WAIT

Behaviour:
Decode of id_ctrl:
- ID we = id_ctrl[8]
- ID is_load = id_ctrl[9] & id_ctrl[2] & ~id_ctrl[4]
- rs_used = ~id_ctrl[20]
- rt_used = (id_ctrl[17:15]==3'b000) | (id_ctrl[2] & ~id_ctrl[9])
- A register is never considered a hazard source when it is $0.

Shadow pipeline:
- Registers: ex_{dest,we,load}, mem_{dest,we,load}, wb_{dest,we}.
- Each stage shifts when its *_le is high.
- The EX slot loads zeros when id_nop=1.

FSM states: FLUSH, RUN, MEM_WAIT.

Reset (asynchronous):
- state=FLUSH, flush counter=0, all shadow registers=0
- mem_timeout=0, stall_count=0

FLUSH:
- Outputs: pc_le=0, ifid_le=0, id_nop=1, idex_le=exmem_le=memwb_le=1, fwd=00.
- After FLUSH_CYCLES cycles, go to RUN.

RUN, priority order:
1. mem_busy=1: freeze. All *_le=0, id_nop=0, wait counter cleared, next state MEM_WAIT.
2. Load-use: ex_load & ex_we & ((rs_used & ex_dest==id_rs) | (rt_used & ex_dest==id_rt)). Then pc_le=ifid_le=0, id_nop=1, idex_le=exmem_le=memwb_le=1. Exactly one bubble per load-use.
3. Otherwise all *_le=1 and id_nop=0.

MEM_WAIT:
- Freeze while mem_busy=1; the wait counter increments each cycle.
- mem_busy=0: return to RUN and evaluate RUN rules in that same cycle.
- Counter reaches WAIT_TIMEOUT: set mem_timeout (sticky until reset), force one advance cycle, go to RUN.

Forwarding (combinational, all states except FLUSH):
- Per operand, first match wins: EX (ex_we, not load) -> 01, MEM (mem_we) -> 10, WB (wb_we) -> 11, else 00.
- Destination 0 never matches.
- During a freeze the selects reflect the held shadow contents.

stall_count:
- Increments once per cycle with pc_le=0 in RUN or MEM_WAIT.
- Saturates at all-ones.

Other rules:
- Reset mid-freeze or mid-stall aborts immediately to FLUSH; no output glitch after reset deassertion besides FLUSH values.
- Latency: hazard response is same-cycle combinational. State and shadow registers update on the clock edge.

Decomposition:
- Package ppu_ctrl_pkg holds:
  - control-vector bit-index constants (CTRL_LOAD=9, CTRL_RFEN=8, CTRL_MEMEN=2, CTRL_MEMRW=4, CTRL_R31=20, CTRL_SRC_HI=17, CTRL_SRC_LO=15)
  - forwarding-select encodings
  - FSM state encodings
- One natural sub-module, ppu_forward_unit: the combinational priority comparator, instanced once per operand.

Test Plan:
- Reset then FLUSH: reset 2 cycles, release -> id_nop=1 and pc_le=0 for exactly 3 cycles, then pc_le=1 and id_nop=0.
- EX forwarding: ADDIU $5,$0,7 then SUBU $6,$5,$5 back-to-back -> while SUBU is in ID, fwd_a_sel=fwd_b_sel=01, no stall.
- Load-use: LBU $4,0($1) then SUBU $7,$4,$2 -> one cycle pc_le=0 and id_nop=1, then fwd_a_sel=10, stall_count=1.
- $0 immunity: ADDIU $0,$0,1 then SUBU $3,$0,$0 -> fwd selects 00, no stall.
- Memory wait: mem_busy high 4 cycles with SB in MEM -> all *_le=0 for 4 cycles, resume on fifth, stall_count +4.
- Watchdog: WAIT_TIMEOUT=8, mem_busy stuck high -> after 8 wait cycles mem_timeout=1 and one advance cycle. A mid-wait reset clears mem_timeout and returns to FLUSH.
